// File: rtl/mips_pkg.sv
// Shared MIPS datapath encodings: ALU select codes, main-control ALUOp codes and R-type funct fields.
package mips_pkg;

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_MUL = 4'b0011;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ORI   = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

endpackage

// File: rtl/alu_control.sv
// Combinational ALUOp/funct decoder producing the ALU select and an unsupported-funct flag.
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] sel_o,
  output logic       illegal_o
);

  always_comb begin
    sel_o     = SEL_ADD;
    illegal_o = 1'b0;
    case (alu_op_e'(alu_op_i))
      ALUOP_ADD: sel_o = SEL_ADD;
      ALUOP_SUB: sel_o = SEL_SUB;
      ALUOP_ORI: sel_o = SEL_OR;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: sel_o = SEL_ADD;
          FUNCT_SUB: sel_o = SEL_SUB;
          FUNCT_AND: sel_o = SEL_AND;
          FUNCT_OR:  sel_o = SEL_OR;
          FUNCT_SLT: sel_o = SEL_SLT;
          FUNCT_MUL: sel_o = SEL_MUL;
          // Unknown R-type ops fall back to add so the ALU still sees a defined select.
          default: begin
            sel_o     = SEL_ADD;
            illegal_o = 1'b1;
          end
        endcase
      end
      default: sel_o = SEL_ADD;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding, load-use stall and flush.
module ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic [RA_W-1:0]   i_rs,
  input  logic [RA_W-1:0]   i_rt,
  input  logic [RA_W-1:0]   i_rd,
  input  logic [15:0]       i_imm,
  input  logic [1:0]        i_alu_op,
  input  logic [5:0]        i_funct,
  input  logic              i_alu_src,
  input  logic              i_reg_dst,
  input  logic              i_reg_write,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_flush,
  input  logic              i_exmem_reg_write,
  input  logic [RA_W-1:0]   i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_data,
  input  logic              i_memwb_reg_write,
  input  logic [RA_W-1:0]   i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_data,
  output logic              o_stall,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_op1,
  output logic [DATA_W-1:0] o_op2,
  output logic [3:0]        o_sel,
  output logic [DATA_W-1:0] o_store_data,
  output logic [RA_W-1:0]   o_dest,
  output logic              o_reg_write,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_illegal
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [RA_W-1:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [15:0]       imm_q, imm_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [5:0]        funct_q, funct_d;
  logic              alu_src_q, alu_src_d, reg_dst_q, reg_dst_d;
  logic              reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;

  logic [RA_W-1:0]   ex_dest;
  logic              stall;
  logic              load_bubble;
  logic [3:0]        sel;
  logic              illegal;

  assign ex_dest = reg_dst_q ? rd_q : rt_q;

  assign stall = !rst && valid_q && mem_read_q && (ex_dest != '0) && i_valid &&
                 ((ex_dest == i_rs) || (ex_dest == i_rt));
  assign load_bubble = i_flush || stall;

  always_comb begin
    valid_d     = 1'b0;
    rs_data_d   = '0;
    rt_data_d   = '0;
    rs_d        = '0;
    rt_d        = '0;
    rd_d        = '0;
    imm_d       = '0;
    alu_op_d    = '0;
    funct_d     = '0;
    alu_src_d   = 1'b0;
    reg_dst_d   = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    if (!load_bubble) begin
      valid_d     = i_valid;
      rs_data_d   = i_rs_data;
      rt_data_d   = i_rt_data;
      rs_d        = i_rs;
      rt_d        = i_rt;
      rd_d        = i_rd;
      imm_d       = i_imm;
      alu_op_d    = i_alu_op;
      funct_d     = i_funct;
      alu_src_d   = i_alu_src;
      reg_dst_d   = i_reg_dst;
      reg_write_d = i_reg_write;
      mem_read_d  = i_mem_read;
      mem_write_d = i_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      alu_op_q    <= '0;
      funct_q     <= '0;
      alu_src_q   <= 1'b0;
      reg_dst_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      funct_q     <= funct_d;
      alu_src_q   <= alu_src_d;
      reg_dst_q   <= reg_dst_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Index 0 resolves rs, index 1 resolves rt; the nearer EX/MEM result wins over MEM/WB.
  logic [RA_W-1:0]   src_reg [2];
  logic [DATA_W-1:0] src_rf  [2];
  logic [DATA_W-1:0] src_fwd [2];

  assign src_reg[0] = rs_q;
  assign src_reg[1] = rt_q;
  assign src_rf[0]  = rs_data_q;
  assign src_rf[1]  = rt_data_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_exmem, hit_memwb;
      assign hit_exmem = i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == src_reg[gi]);
      assign hit_memwb = i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == src_reg[gi]);
      assign src_fwd[gi] = hit_exmem ? i_exmem_data :
                           hit_memwb ? i_memwb_data : src_rf[gi];
    end
  endgenerate

  alu_control u_alu_control (
    .alu_op_i  (alu_op_q),
    .funct_i   (funct_q),
    .sel_o     (sel),
    .illegal_o (illegal)
  );

  assign o_stall      = stall;
  assign o_valid      = valid_q;
  assign o_op1        = src_fwd[0];
  assign o_op2        = alu_src_q ? {{(DATA_W-16){imm_q[15]}}, imm_q} : src_fwd[1];
  assign o_store_data = src_fwd[1];
  assign o_sel        = sel;
  assign o_dest       = ex_dest;
  assign o_reg_write  = reg_write_q && valid_q;
  assign o_mem_read   = mem_read_q && valid_q;
  assign o_mem_write  = mem_write_q && valid_q;
  assign o_illegal    = illegal && valid_q;

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage of the MIPS datapath, directly upstream of the ALU. Captures the decoded instruction bundle each cycle, generates the ALU's 4-bit `Sel` from ALUOp/funct, and resolves both ALU operands via EX/MEM and MEM/WB forwarding plus immediate selection. Detects load-use hazards: it stalls decode and inserts a bubble. It also handles branch flushes.

## Interface
- `DATA_W`, 32: operand/result width.
- `RA_W`, 5: register address width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: decode presents a valid instruction.
- `i_rs_data`, `i_rt_data` in DATA_W: register file read data.
- `i_rs`, `i_rt`, `i_rd` in RA_W: source and destination register fields.
- `i_imm` in 16: raw immediate.
- `i_alu_op` in 2: main-control ALUOp.
- `i_funct` in 6: R-type funct.
- `i_alu_src` in 1: 1 = op2 is the immediate.
- `i_reg_dst` in 1: 1 = dest is rd, 0 = dest is rt.
- `i_reg_write`, `i_mem_read`, `i_mem_write` in 1: control bits.
- `i_flush` in 1: branch taken; squash the instruction entering ID/EX.
- `i_exmem_reg_write` in 1, `i_exmem_rd` in RA_W, `i_exmem_data` in DATA_W: EX/MEM forward source.
- `i_memwb_reg_write` in 1, `i_memwb_rd` in RA_W, `i_memwb_data` in DATA_W: MEM/WB forward source.
- `o_stall` out 1: hold PC and IF/ID this cycle.
- `o_valid` out 1: EX-stage instruction valid.
- `o_op1`, `o_op2` out DATA_W: to ALU `i_op1`/`i_op2`.
- `o_sel` out 4: to ALU `Sel`.
- `o_store_data` out DATA_W: forwarded rt value for stores.
- `o_dest` out RA_W: resolved destination register.
- `o_reg_write`, `o_mem_read`, `o_mem_write` out 1: control bits, gated by valid.
- `o_illegal` out 1: unsupported funct for ALUOp=10.

## Operation
- ID/EX register loads on every rising edge. Load priority:
  - `rst` loads all zeros.
  - `i_flush` loads a bubble.
  - `o_stall` loads a bubble.
  - Otherwise loads the incoming bundle.
- A bubble has valid=0 and all control bits 0. Data fields are don't-care but held at 0.
- `o_stall` is combinational and equals registered `mem_read & valid & (dest != 0) & i_valid & (dest == i_rs | dest == i_rt)`. It is forced to 0 during `rst`.
- Sel decode, with ALUOp in brackets:
  - [00] 0010 (add)
  - [01] 0110 (sub)
  - [11] 0001 (ori)
  - [10] funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111, 011000→0011.
  - [10] any other funct gives 0010 with `o_illegal`=1.
  - `o_illegal` is 0 when not valid.
- Forwarding, evaluated independently for rs and rt:
  - EX/MEM wins if its reg_write=1, its rd != 0 and its rd matches.
  - Else MEM/WB under the same rule.
  - Else the registered register-file data is used.
  - Register 0 is never forwarded.
- Operands:
  - `o_op1` = forwarded rs.
  - `o_op2` = `alu_src` ? sign-extended imm : forwarded rt.
  - `o_store_data` = forwarded rt, always.
- `o_dest` = `reg_dst` ? rd : rt.
- Outputs `o_reg_write`, `o_mem_read` and `o_mem_write` are ANDed with valid.

## Timing
- One-cycle latency: a bundle accepted at edge N drives EX outputs during cycle N+1.
- Forward and operand muxes are combinational from registered fields and same-cycle `i_exmem_*`/`i_memwb_*`. There is zero added latency from forward sources to `o_op*`.
- Reset values: all control outputs 0, `o_sel`=0010, `o_op1`=`o_op2`=`o_store_data`=0, `o_dest`=0, `o_stall`=0.
- A load-use hazard costs exactly one bubble. The stalled instruction stays on the decode inputs and is accepted the next cycle. Its value then arrives through the MEM/WB forward path.
- Flush and stall in the same cycle: one bubble, and `o_stall` is still asserted.
- `rst` mid-stream discards the in-flight instruction with no partial state.

## Structure
- The shared package `mips_pkg` holds:
  - ALU Sel constants: AND, OR, ADD, SUB, SLT, MUL.
  - ALUOp codes.
  - funct codes.
  - The ALU module uses the same Sel constants.
- Sub-module `alu_control`: purely combinational ALUOp+funct → Sel/illegal decoder. It is instantiated on the registered fields.

## Test plan
- Reset: assert `rst` 2 cycles → all outputs at reset values, `o_sel`=0010; first valid add (rs=1 data 5, rt=2 data 7, funct 100000) → next cycle `o_op1`=5, `o_op2`=7, `o_sel`=0010.
- Forward priority: EX instr has rs=3; EX/MEM rd=3 data 0xAA and MEM/WB rd=3 data 0xBB, both writing → `o_op1`=0xAA. With EX/MEM reg_write=0 → 0xBB. With rd=0 on both → regfile value.
- Load-use: lw writing $4 in EX, decode presents add rs=$4 → `o_stall`=1 for one cycle, next EX valid=0. The add then enters, and MEM/WB rd=4 data 0x1234 gives `o_op1`=0x1234.
- Flush: `i_flush`=1 with a valid sw → next cycle `o_valid`=0 and `o_mem_write`=0. Flush+hazard in the same cycle → single bubble.
- Immediate: `alu_src`=1, imm 0xFFFE → `o_op2`=0xFFFFFFFE. Also `o_store_data` = forwarded rt.
- Decode sweep: every ALUOp/funct pair → listed Sel. Funct 000111 with ALUOp=10 → `o_illegal`=1, Sel 0010.
